// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the single regfile write port between the in-order WB (wb0) and a long-latency
// unit (wb1), registers the granted write, and tracks outstanding wb1 results per GPR.
module regfile_wb_arbiter #(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 5,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              wb0_valid,
  output logic              wb0_ready,
  input  logic [ADDR_W-1:0] wb0_addr,
  input  logic [DATA_W-1:0] wb0_data,
  input  logic              wb1_valid,
  output logic              wb1_ready,
  input  logic [ADDR_W-1:0] wb1_addr,
  input  logic [DATA_W-1:0] wb1_data,
  input  logic              mark_valid,
  input  logic [ADDR_W-1:0] mark_addr,
  input  logic [ADDR_W-1:0] query_addr1,
  output logic              query_busy1,
  input  logic [ADDR_W-1:0] query_addr2,
  output logic              query_busy2,
  output logic              rf_w_enable,
  output logic [ADDR_W-1:0] rf_w_addr,
  output logic [DATA_W-1:0] rf_w_data
);
  localparam int NREG = 1 << ADDR_W;
  localparam int CW   = $clog2(STARVE_LIMIT + 1);

  logic [CW-1:0]     starve_cnt, starve_nxt;
  logic [NREG-1:0]   busy, busy_nxt;
  logic              force1, wb0_hs, wb1_hs, any_hs;
  logic [ADDR_W-1:0] gnt_addr;
  logic [DATA_W-1:0] gnt_data;

  // wb1 gets the port when it has waited STARVE_LIMIT cycles or wb0 is idle.
  assign force1    = (starve_cnt == CW'(STARVE_LIMIT));
  assign wb0_ready = resetn & ~force1;
  assign wb1_ready = resetn & (force1 | ~wb0_valid);
  assign wb0_hs    = wb0_valid & wb0_ready;
  assign wb1_hs    = wb1_valid & wb1_ready;
  assign any_hs    = wb0_hs | wb1_hs;
  assign gnt_addr  = wb1_hs ? wb1_addr : wb0_addr;
  assign gnt_data  = wb1_hs ? wb1_data : wb0_data;

  always_comb begin
    starve_nxt = starve_cnt;
    if (!wb1_valid || wb1_hs)
      starve_nxt = '0;
    else if (starve_cnt != CW'(STARVE_LIMIT))
      starve_nxt = starve_cnt + 1'b1;
  end

  // Clear-then-set so a fresh mark beats the retiring write to the same register.
  always_comb begin
    busy_nxt = busy;
    if (wb1_hs)
      busy_nxt[wb1_addr] = 1'b0;
    if (mark_valid)
      busy_nxt[mark_addr] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      starve_cnt  <= '0;
      busy        <= '0;
      rf_w_enable <= 1'b0;
      rf_w_addr   <= '0;
      rf_w_data   <= '0;
    end else begin
      starve_cnt  <= starve_nxt;
      busy        <= busy_nxt;
      rf_w_enable <= any_hs && (gnt_addr != '0);
      if (any_hs) begin
        rf_w_addr <= gnt_addr;
        rf_w_data <= gnt_data;
      end
    end
  end

  assign query_busy1 = busy[query_addr1];
  assign query_busy2 = busy[query_addr2];
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: expected regfile writes go into a queue that a
// negedge monitor drains; handshake readies and scoreboard bits are checked inline.
module tb_regfile_wb_arbiter;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  logic              clk = 1'b0;
  logic              resetn;
  logic              wb0_valid, wb1_valid, mark_valid;
  logic              wb0_ready, wb1_ready;
  logic [ADDR_W-1:0] wb0_addr, wb1_addr, mark_addr, query_addr1, query_addr2;
  logic [DATA_W-1:0] wb0_data, wb1_data;
  logic              query_busy1, query_busy2;
  logic              rf_w_enable;
  logic [ADDR_W-1:0] rf_w_addr;
  logic [DATA_W-1:0] rf_w_data;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;
  wr_t exp_q[$];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .STARVE_LIMIT(4)) dut (
    .clk(clk), .resetn(resetn),
    .wb0_valid(wb0_valid), .wb0_ready(wb0_ready), .wb0_addr(wb0_addr), .wb0_data(wb0_data),
    .wb1_valid(wb1_valid), .wb1_ready(wb1_ready), .wb1_addr(wb1_addr), .wb1_data(wb1_data),
    .mark_valid(mark_valid), .mark_addr(mark_addr),
    .query_addr1(query_addr1), .query_busy1(query_busy1),
    .query_addr2(query_addr2), .query_busy2(query_busy2),
    .rf_w_enable(rf_w_enable), .rf_w_addr(rf_w_addr), .rf_w_data(rf_w_data)
  );

  // Monitor: every enabled write must match the oldest expected write.
  always @(negedge clk) begin
    if (rf_w_enable) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got addr=%0d data=%h, required no write",
                 rf_w_addr, rf_w_data);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        if (rf_w_addr !== e.addr || rf_w_data !== e.data) begin
          errors++;
          $display("FAIL write_payload: got addr=%0d data=%h, required addr=%0d data=%h",
                   rf_w_addr, rf_w_data, e.addr, e.data);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic idle();
    wb0_valid = 1'b0; wb1_valid = 1'b0; mark_valid = 1'b0;
  endtask

  task automatic test1();
    wb0_valid = 1'b1; wb0_addr = 5'd3; wb0_data = 32'h0000_1234;
    #1;
    chk("t1_wb0_ready", 64'(wb0_ready), 64'd1);
    expect_wr(5'd3, 32'h0000_1234);
    step();
    idle();
    #1;
    chk("t1_rf_en", 64'(rf_w_enable), 64'd1);
    chk("t1_rf_addr", 64'(rf_w_addr), 64'd3);
    chk("t1_rf_data", 64'(rf_w_data), 64'h1234);
    step();
    chk("t1_rf_en_off", 64'(rf_w_enable), 64'd0);
  endtask

  initial begin
    int n0, n1;
    logic g1;
    resetn = 1'b0; idle();
    wb0_addr = '0; wb0_data = '0; wb1_addr = '0; wb1_data = '0; mark_addr = '0;
    query_addr1 = '0; query_addr2 = '0;
    #1;
    chk("rst_wb0_ready", 64'(wb0_ready), 64'd0);
    chk("rst_wb1_ready", 64'(wb1_ready), 64'd0);
    step(); step();
    chk("rst_rf_en", 64'(rf_w_enable), 64'd0);
    chk("rst_rf_addr", 64'(rf_w_addr), 64'd0);
    chk("rst_rf_data", 64'(rf_w_data), 64'd0);
    resetn = 1'b1;
    step();

    // 1: single wb0 write
    test1();

    // 2: both sources continuously valid; wb1 forced at cycles 4 and 9
    n0 = 0; n1 = 0;
    wb0_addr = 5'd6; wb1_addr = 5'd10;
    for (int c = 0; c < 10; c++) begin
      g1 = (c == 4) || (c == 9);
      wb0_valid = 1'b1; wb0_data = 32'hA000_0000 + 32'(n0);
      wb1_valid = 1'b1; wb1_data = 32'hB000_0000 + 32'(n1);
      #1;
      chk($sformatf("t2_wb0_ready_c%0d", c), 64'(wb0_ready), 64'(!g1));
      chk($sformatf("t2_wb1_ready_c%0d", c), 64'(wb1_ready), 64'(g1));
      if (g1) begin
        expect_wr(5'd10, 32'hB000_0000 + 32'(n1));
        n1++;
      end else begin
        expect_wr(5'd6, 32'hA000_0000 + 32'(n0));
        n0++;
      end
      step();
    end
    idle();
    step();

    // 3: mark 7, then retire it through wb1
    mark_valid = 1'b1; mark_addr = 5'd7; query_addr1 = 5'd7;
    #1;
    chk("t3_busy_same_cycle", 64'(query_busy1), 64'd0);
    step();
    idle();
    #1;
    chk("t3_busy_set", 64'(query_busy1), 64'd1);
    wb1_valid = 1'b1; wb1_addr = 5'd7; wb1_data = 32'hCAFE_0007;
    #1;
    chk("t3_wb1_ready", 64'(wb1_ready), 64'd1);
    expect_wr(5'd7, 32'hCAFE_0007);
    step();
    idle();
    #1;
    chk("t3_busy_cleared", 64'(query_busy1), 64'd0);
    chk("t3_rf_addr", 64'(rf_w_addr), 64'd7);
    step();

    // 4: set and clear of 9 in the same cycle, set wins
    mark_valid = 1'b1; mark_addr = 5'd9; query_addr2 = 5'd9;
    step();
    #1;
    chk("t4_busy_set", 64'(query_busy2), 64'd1);
    wb1_valid = 1'b1; wb1_addr = 5'd9; wb1_data = 32'hCAFE_0009;
    expect_wr(5'd9, 32'hCAFE_0009);
    step();
    idle();
    #1;
    chk("t4_busy_kept", 64'(query_busy2), 64'd1);
    step();

    // 5: writes and marks to r0 are squashed
    wb0_valid = 1'b1; wb0_addr = 5'd0; wb0_data = 32'hFFFF_FFFF;
    mark_valid = 1'b1; mark_addr = 5'd0; query_addr1 = 5'd0;
    #1;
    chk("t5_wb0_ready", 64'(wb0_ready), 64'd1);
    step();
    idle();
    #1;
    chk("t5_rf_en", 64'(rf_w_enable), 64'd0);
    chk("t5_busy0", 64'(query_busy1), 64'd0);
    step();

    // 6: reset with a live write and a busy register
    mark_valid = 1'b1; mark_addr = 5'd5; query_addr1 = 5'd5;
    wb0_valid = 1'b1; wb0_addr = 5'd4; wb0_data = 32'h0000_0444;
    expect_wr(5'd4, 32'h0000_0444);
    step();
    idle();
    wb0_valid = 1'b1; wb1_valid = 1'b1;
    resetn = 1'b0;
    #1;
    chk("t6_rf_en_live", 64'(rf_w_enable), 64'd1);
    chk("t6_busy5_live", 64'(query_busy1), 64'd1);
    chk("t6_wb0_ready_rst", 64'(wb0_ready), 64'd0);
    chk("t6_wb1_ready_rst", 64'(wb1_ready), 64'd0);
    step();
    chk("t6_rf_en", 64'(rf_w_enable), 64'd0);
    chk("t6_rf_addr", 64'(rf_w_addr), 64'd0);
    chk("t6_rf_data", 64'(rf_w_data), 64'd0);
    chk("t6_busy5", 64'(query_busy1), 64'd0);
    idle();
    resetn = 1'b1;
    step();
    test1();

    step(); step();
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
